// File: rtl/game_controller.sv
// game_controller: turn-based World War Math state machine.
// Drives velocity and launch point, scores each shot from the animation stage's positions.
module game_controller #(
   parameter logic [9:0]  X_INIT    = 10'd210,
   parameter logic [9:0]  Y_INIT    = 10'd463,
   parameter logic [3:0]  VX_INIT   = 4'd4,
   parameter logic [3:0]  VY_INIT   = 4'd8,
   parameter logic [3:0]  MAX_SHOTS = 4'd5,
   parameter logic [10:0] TGT_TOP   = 11'd470,
   parameter logic [10:0] GROUND_Y  = 11'd475,
   parameter logic [10:0] RIGHT_X   = 11'd775,
   parameter logic [49:0] T_AIR_MAX = 50'd60
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        btn_start,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_right,
   input  logic        btn_left,
   input  logic [9:0]  projectileCenterX,
   input  logic [9:0]  projectileCenterY,
   input  logic [9:0]  targetCenterX,
   input  logic [49:0] t_air,
   output logic        q_I,
   output logic        q_P1Shoot,
   output logic        q_Animate,
   output logic        q_Done,
   output logic [3:0]  vX,
   output logic [3:0]  vY,
   output logic [9:0]  X_INITIAL,
   output logic [9:0]  Y_INITIAL,
   output logic [3:0]  shots,
   output logic        win
);
   localparam logic [3:0] S_I = 4'b0001, S_SHOOT = 4'b0010, S_ANIM = 4'b0100, S_DONE = 4'b1000;
   logic [3:0]  state;
   logic [10:0] px, px5, py2, t_lo, t_hi;
   logic        hit, miss, vy_inc, vy_dec, vx_inc, vx_dec;
   logic [3:0]  vx_nxt, vy_nxt;
   assign {q_Done, q_Animate, q_P1Shoot, q_I} = state;
   assign X_INITIAL = X_INIT;
   assign Y_INITIAL = Y_INIT;
   // 11-bit arithmetic so box edges near 1023 cannot wrap; left target edge clamps at 0
   always_comb begin
      px   = {1'b0, projectileCenterX};
      px5  = px + 11'd5;
      py2  = {1'b0, projectileCenterY} + 11'd2;
      t_lo = targetCenterX >= 10'd10 ? {1'b0, targetCenterX} - 11'd10 : 11'd0;
      t_hi = {1'b0, targetCenterX} + 11'd10;
      hit  = t_air != '0 && px5 >= t_lo && px <= t_hi && py2 >= TGT_TOP;
      miss = t_air != '0 && !hit && (py2 >= GROUND_Y || px >= RIGHT_X || t_air >= T_AIR_MAX);
      vy_inc = btn_up & ~btn_down;
      vy_dec = btn_down & ~btn_up;
      vx_inc = btn_right & ~btn_left;
      vx_dec = btn_left & ~btn_right;
      vy_nxt = vy_inc && vY != 4'd15 ? vY + 4'd1 : vy_dec && vY != 4'd0 ? vY - 4'd1 : vY;
      vx_nxt = vx_inc && vX != 4'd15 ? vX + 4'd1 : vx_dec && vX != 4'd0 ? vX - 4'd1 : vX;
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= S_I;
         vX    <= VX_INIT;
         vY    <= VY_INIT;
         shots <= 4'd0;
         win   <= 1'b0;
      end else begin
         case (state)
            S_I: if (btn_start) begin
               state <= S_SHOOT;
               vX    <= VX_INIT;
               vY    <= VY_INIT;
               shots <= 4'd0;
               win   <= 1'b0;
            end
            S_SHOOT: if (btn_start) begin
               state <= S_ANIM;
               shots <= shots + 4'd1;
            end else begin
               vX <= vx_nxt;
               vY <= vy_nxt;
            end
            S_ANIM: if (hit) begin
               state <= S_DONE;
               win   <= 1'b1;
            end else if (miss) begin
               state <= shots == MAX_SHOTS ? S_DONE : S_SHOOT;
               win   <= 1'b0;
            end
            S_DONE: if (btn_start) state <= S_I;
            default: state <= S_I;
         endcase
      end
   end
endmodule
